add_share_arb: RTL and testbench
================================

Name: add_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-cycle-latency adder (start/valid protocol, y = a + b mod 2^W) among N requesters.
- Holds a req/gnt handshake per requester, drives the adder's start/a/b, waits for valid, and routes the sum back to the granted requester.
- Sits between the requesting blocks and the shared adder instance.
- Includes a watchdog so a missing adder valid cannot hang the arbiter.

Parameters:
- W, 8, operand/result width; must match the adder.
- N, 4, number of requesters (2..8).
- TIMEOUT, 4, maximum cycles spent in WAIT before declaring an error (>=2).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N  per-requester request; held until the matching gnt is seen
- op_a  input  N*W  packed operand A; requester i uses bits [i*W +: W]
- op_b  input  N*W  packed operand B, same packing as op_a
- gnt  output  N  one-hot grant, high for exactly 1 cycle
- rsp_valid  output  N  one-hot result strobe, 1 cycle
- rsp_y  output  W  result; meaningful only while any rsp_valid bit is high
- err  output  1  1-cycle pulse on adder timeout
- add_start  output  1  start to the adder
- add_a  output  W  operand A to the adder
- add_b  output  W  operand B to the adder
- add_y  input  W  adder result
- add_valid  input  1  adder valid
- op_count  output  16  completed-operation count (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset (async, any state):
  - state = IDLE, round-robin pointer ptr = 0, timeout counter = 0.
  - gnt, rsp_valid, rsp_y, err, add_start, add_a, add_b and op_count are all 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If req != 0, pick the winner as the first set req bit searching from ptr upward, wrapping N-1 -> 0.
  - At that edge: owner <= winner; add_a/add_b <= winner's operands; add_start <= 1; gnt <= onehot(winner); go to ISSUE.
  - If req == 0, remain in IDLE.
- ISSUE: lasts exactly 1 cycle, with add_start and gnt high. At the next edge add_start <= 0, gnt <= 0, counter <= 0, go to WAIT.
- WAIT:
  - If add_valid: rsp_valid <= onehot(owner), rsp_y <= add_y, ptr <= (owner+1) mod N, go to IDLE.
  - Else if counter == TIMEOUT-1: err <= 1, ptr <= (owner+1) mod N, go to IDLE; no rsp_valid.
  - Else counter increments.
- Latency with a nominal adder, req sampled at cycle 0:
  - gnt and add_start in cycle 1.
  - add_valid in cycle 2.
  - rsp_valid in cycle 3, with state back in IDLE.
  - Peak throughput: 1 op per 3 cycles.
- Handshake:
  - Requester holds req and its operands stable until it sees gnt, then drops req.
  - A req still high in the cycle after gnt (cycle 2) is treated as a new request once the FSM returns to IDLE.
- Arithmetic: the block does no arithmetic itself; rsp_y = add_y verbatim (the adder wraps mod 2^W).
- add_valid while in IDLE or ISSUE is ignored; no response and no error.
- add_a/add_b hold their last issued values until the next issue.
- A req bit dropping while the FSM is in ISSUE or WAIT does not abort the operation.
- Simultaneous requests: only one grant per arbitration. The winner moves to lowest priority and the others keep their relative order (fairness: any held req is granted within N arbitrations).

Optional Feature:
- Macro ADD_SHARE_ARB_STATS_EN.
- Defined:
  - op_count increments by 1 on every rsp_valid, saturating at 0xFFFF.
  - Timeouts do not count.
  - Reset clears op_count to 0.
- Undefined: op_count is tied to 0 and no counter logic is built.

Test Plan:
- Single request: req = 4'b0001, op_a[7:0] = 0x12, op_b[7:0] = 0x34 -> gnt = 0001 and add_start high in cycle 1 only; rsp_valid = 0001 with rsp_y = 0x46 in cycle 3; err = 0.
- Wrap-around: requester 2 with a = 0xFF, b = 0x02 -> rsp_valid = 0100, rsp_y = 0x01.
- Fairness after reset: all four req held high, each dropped after its own gnt -> grants in order 0001, 0010, 0100, 1000, 3 cycles apart; each rsp_y equals that requester's sum.
- Timeout: adder model suppresses add_valid for one op on requester 1 (TIMEOUT = 4) -> err pulses in the 4th WAIT cycle, no rsp_valid; the next pending request (requester 2) is granted normally.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately, with no late rsp_valid after release; then with req = 1010 -> first gnt = 0010 (ptr = 0).
- Stats (macro defined): after 5 completed ops plus 1 timeout -> op_count = 5; with the macro undefined -> op_count stays 0.

Source files
------------

// File: rtl/add_share_arb.sv
// Round-robin arbiter/sequencer sharing one single-cycle adder among N requesters.
// Optional completed-operation counter enabled by defining ADD_SHARE_ARB_STATS_EN.
module add_share_arb #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_y,
  output logic           err,
  output logic           add_start,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  input  logic           add_valid,
  output logic [15:0]    op_count
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   owner, owner_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [PW-1:0]   win;
  logic            found;
  int              idx;
  logic [PW-1:0]   owner_nxt;

  logic [N-1:0]    gnt_d, rsp_valid_d;
  logic [W-1:0]    rsp_y_d, add_a_d, add_b_d;
  logic            err_d, add_start_d;

  // Winner: first set request at or above ptr, wrapping past N-1 back to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign owner_nxt = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    cnt_d       = cnt;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y;
    err_d       = 1'b0;
    add_start_d = 1'b0;
    add_a_d     = add_a;
    add_b_d     = add_b;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d     = win;
          add_a_d     = op_a[int'(win)*W +: W];
          add_b_d     = op_b[int'(win)*W +: W];
          add_start_d = 1'b1;
          gnt_d[win]  = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (add_valid) begin
          rsp_valid_d[owner] = 1'b1;
          rsp_y_d            = add_y;
          ptr_d              = owner_nxt;
          state_d            = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Adder never answered: release the slot so other requesters progress.
          err_d   = 1'b1;
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      err       <= 1'b0;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_y     <= rsp_y_d;
      err       <= err_d;
      add_start <= add_start_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
    end
  end

`ifdef ADD_SHARE_ARB_STATS_EN
  logic [15:0] op_cnt;

  // Counts responses only; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (|rsp_valid_d && op_cnt != 16'hFFFF) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end

  assign op_count = op_cnt;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Directed testbench for add_share_arb with a registered single-cycle adder model.
module tb_add_share_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           err;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           add_valid;
  logic [15:0]    op_count;

  logic suppress;
  logic inject;

  int checks;
  int errors;

  add_share_arb #(.W(W), .N(N), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .err       (err),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .add_valid (add_valid),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: result and valid one cycle after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid <= 1'b0;
      add_y     <= '0;
    end else begin
      add_valid <= (add_start && !suppress) || inject;
      add_y     <= add_a + add_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    req      = '0;
    op_a     = '0;
    op_b     = '0;
    suppress = 1'b0;
    inject   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    req      = '0;
    op_a     = '0;
    op_b     = '0;
    suppress = 1'b0;
    inject   = 1'b0;
    #1;
    checks++;
    if ({gnt, rsp_valid, err, add_start} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 0", {gnt, rsp_valid, err, add_start});
    end
    checks++;
    if ({rsp_y, add_a, add_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, want 0", {rsp_y, add_a, add_b});
    end
    checks++;
    if (op_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_op_count: got %h, want 0", op_count);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    do_reset();
    op_a[7:0] = 8'h12;
    op_b[7:0] = 8'h34;
    req = 4'b0001;
    step();
    checks++;
    if ({gnt, add_start} !== 5'b0001_1) begin
      errors++;
      $display("FAIL single_gnt: got gnt=%b start=%b, want 0001/1", gnt, add_start);
    end
    checks++;
    if ({add_a, add_b} !== 16'h1234) begin
      errors++;
      $display("FAIL single_operands: got %h, want 1234", {add_a, add_b});
    end
    req = 4'b0000;
    step();
    checks++;
    if ({gnt, add_start, rsp_valid} !== 9'b0) begin
      errors++;
      $display("FAIL single_c2: got gnt=%b start=%b rsp=%b, want 0", gnt, add_start, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_y !== 8'h46 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got rsp=%b y=%h err=%b, want 0001/46/0", rsp_valid, rsp_y, err);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_rsp_pulse: got %b, want 0000", rsp_valid);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    op_a[23:16] = 8'hFF;
    op_b[23:16] = 8'h02;
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_gnt: got %b, want 0100", gnt);
    end
    req = 4'b0000;
    step();
    step();
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_y !== 8'h01) begin
      errors++;
      $display("FAIL wrap_rsp: got rsp=%b y=%h, want 0100/01", rsp_valid, rsp_y);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];
    logic [7:0] s_v [4];
    logic [3:0] one;
    a_v = '{8'h01, 8'h80, 8'hF0, 8'h7F};
    b_v = '{8'h02, 8'h80, 8'h20, 8'h01};
    s_v = '{8'h03, 8'h00, 8'h10, 8'h80};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op_a[i*8 +: 8] = a_v[i];
      op_b[i*8 +: 8] = b_v[i];
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      one = 4'b0001 << i;
      step();
      checks++;
      if (gnt !== one) begin
        errors++;
        $display("FAIL fair_gnt%0d: got %b, want %b", i, gnt, one);
      end
      req[i] = 1'b0;
      step();
      step();
      checks++;
      if (rsp_valid !== one || rsp_y !== s_v[i]) begin
        errors++;
        $display("FAIL fair_rsp%0d: got rsp=%b y=%h, want %b/%h", i, rsp_valid, rsp_y, one, s_v[i]);
      end
    end
  endtask

  task automatic test_timeout;
    logic seen;
    do_reset();
    op_a[15:8]  = 8'h05;
    op_b[15:8]  = 8'h06;
    op_a[23:16] = 8'h30;
    op_b[23:16] = 8'h0C;
    suppress = 1'b1;
    req = 4'b0110;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_gnt1: got %b, want 0010", gnt);
    end
    req = 4'b0100;
    step();
    suppress = 1'b0;
    seen = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      step();
      if (err !== 1'b0 || rsp_valid !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got early err/rsp=1, want 0");
    end
    step();
    checks++;
    if (err !== 1'b1 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_err: got err=%b rsp=%b, want 1/0000", err, rsp_valid);
    end
    step();
    checks++;
    if (err !== 1'b0 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_next: got err=%b gnt=%b, want 0/0100", err, gnt);
    end
    req = 4'b0000;
    step();
    step();
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_y !== 8'h3C) begin
      errors++;
      $display("FAIL timeout_rsp2: got rsp=%b y=%h, want 0100/3c", rsp_valid, rsp_y);
    end
  endtask

  task automatic test_ignore_valid;
    do_reset();
    inject = 1'b1;
    step();
    inject = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 4'b0000 || err !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL idle_valid: got rsp=%b err=%b gnt=%b, want 0", rsp_valid, err, gnt);
    end
  endtask

  task automatic test_reset_mid;
    logic late;
    do_reset();
    op_a[7:0] = 8'h11;
    op_b[7:0] = 8'h22;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rsp_valid, err, add_start, add_a, add_b} !== 26'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, want 0", {gnt, rsp_valid, err, add_start, add_a, add_b});
    end
    step();
    step();
    rst_n = 1'b1;
    late = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rsp_valid !== 4'b0000 || err !== 1'b0) late = 1'b1;
    end
    checks++;
    if (late !== 1'b0) begin
      errors++;
      $display("FAIL midreset_late: got late rsp/err=1, want 0");
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_gnt: got %b, want 0010", gnt);
    end
    req = 4'b1000;
    step();
    req = 4'b0000;
  endtask

  task automatic test_stats;
    logic [15:0] exp_cnt;
`ifdef ADD_SHARE_ARB_STATS_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op_a[31:24] = 8'(i);
      op_b[31:24] = 8'h01;
      req = 4'b1000;
      step();
      req = 4'b0000;
      step();
      step();
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_y !== 8'(i + 1)) begin
        errors++;
        $display("FAIL stats_op%0d: got rsp=%b y=%h, want 1000/%h", i, rsp_valid, rsp_y, 8'(i + 1));
      end
    end
    suppress = 1'b1;
    req = 4'b1000;
    step();
    req = 4'b0000;
    step();
    suppress = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL stats_count: got %0d, want %0d", op_count, exp_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_ignore_valid();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
